// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit CPU bus: RAM, loader-filled program store,
// an output FIFO with status, and a free-running tick counter.
module cpu_mem_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int PROG_BYTES = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_address,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_write,
    output logic [7:0] cpu_rdata,
    output logic       cpu_reset,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_done,
    output logic       load_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;
    localparam int PW  = $clog2(PROG_BYTES);
    localparam logic [7:0]    PROG_LIMIT = 8'(PROG_BYTES);
    localparam logic [PW-1:0] PTR_LAST   = PW'(PROG_BYTES - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic            prog_we;

    logic [7:0]      prog_mem [PROG_BYTES];
    logic [7:0]      ram      [16];
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [7:0]      tick;

    logic            run, cpu_wr, ram_we, push_req, push_acc, pop, ov_clr;
    logic            empty, full;
    logic [7:0]      status;

    // Loader FSM: next state and program-store write enable
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        prog_we   = 1'b0;
        case (state)
            ST_LOAD: begin
                if (load_start) begin
                    ptr_nxt = '0;
                end else begin
                    if (load_valid) begin
                        prog_we = 1'b1;
                        ptr_nxt = ptr + 1'b1;
                        if (ptr == PTR_LAST) state_nxt = ST_RUN;
                    end
                    if (load_done) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_nxt = ST_LOAD;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Program store is deliberately not reset so a reset keeps the loaded image
    always_ff @(posedge clk) begin
        if (prog_we && !reset) prog_mem[ptr] <= load_data;
    end

    assign run        = (state == ST_RUN);
    assign cpu_reset  = !run;
    assign load_ready = !run;

    // CPU writes only take effect while the CPU is running
    assign cpu_wr   = cpu_write && run;
    assign ram_we   = cpu_wr && (cpu_address[7:4] == 4'h0);
    assign push_req = cpu_wr && (cpu_address == 8'h10);
    assign ov_clr   = cpu_wr && (cpu_address == 8'h11) && cpu_wdata[2];

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign push_acc  = push_req && (!full || pop);
    assign status    = {5'b00000, overflow, full, empty};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tick     <= 8'h00;
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
        end else begin
            tick <= tick + 8'h01;
            if (ram_we) ram[cpu_address[3:0]] <= cpu_wdata;
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped push outranks a simultaneous clear
            if (push_req && !push_acc) overflow <= 1'b1;
            else if (ov_clr)           overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) fifo_mem[wr_ptr] <= cpu_wdata;
    end

    always_comb begin
        cpu_rdata = 8'h00;
        if (cpu_address[7]) begin
            if ({1'b0, cpu_address[6:0]} < PROG_LIMIT) cpu_rdata = prog_mem[cpu_address[PW-1:0]];
        end else if (cpu_address[7:4] == 4'h0) begin
            cpu_rdata = ram[cpu_address[3:0]];
        end else if (cpu_address == 8'h11) begin
            cpu_rdata = status;
        end else if (cpu_address == 8'h12) begin
            cpu_rdata = tick;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: directed test-plan steps followed by
// randomized traffic, all checked against a queue/array reference model.
module tb_cpu_mem_responder;

    localparam int DEPTH = 8;
    localparam int PROG  = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_address, cpu_wdata, cpu_rdata;
    logic       cpu_write, cpu_reset;
    logic       load_start, load_valid, load_done, load_ready;
    logic [7:0] load_data, out_data;
    logic       out_valid, out_ready;

    cpu_mem_responder #(.FIFO_DEPTH(DEPTH), .PROG_BYTES(PROG)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_reset(cpu_reset),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_done(load_done), .load_ready(load_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_ram  [16];
    logic [7:0] m_prog [PROG];
    bit         m_known[PROG];
    bit         m_run;
    int         m_ptr;
    bit         m_ov;
    logic [7:0] m_tick;
    logic [7:0] exp_q[$];
    bit         chk_en = 1'b0;
    bit         ov_set, ov_clr;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Bit 8 says whether the expected value is known (unloaded program bytes are not)
    function automatic logic [8:0] model_read(input logic [7:0] a);
        if (a >= 8'h80) return {m_known[a - 8'h80], m_prog[a - 8'h80]};
        if (a < 8'h10) return {1'b1, m_ram[a]};
        if (a == 8'h11) return {1'b1, 5'b0, m_ov, exp_q.size() == DEPTH, exp_q.size() == 0};
        if (a == 8'h12) return {1'b1, m_tick};
        return 9'h100;
    endfunction

    // Model update at each rising edge, from the inputs held across it
    initial begin
        for (int i = 0; i < PROG; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
                exp_q.delete();
                m_run = 1'b0; m_ptr = 0; m_ov = 1'b0; m_tick = 8'h00;
                chk_en = 1'b1;
            end else begin
                ov_set = 1'b0; ov_clr = 1'b0;
                m_tick = m_tick + 8'h01;
                if (m_run) begin
                    if (cpu_write) begin
                        if (cpu_address < 8'h10) m_ram[cpu_address] = cpu_wdata;
                        else if (cpu_address == 8'h10) begin
                            // the monitor has already removed any byte popped at this edge
                            if (exp_q.size() < DEPTH) exp_q.push_back(cpu_wdata);
                            else ov_set = 1'b1;
                        end else if (cpu_address == 8'h11 && cpu_wdata[2]) ov_clr = 1'b1;
                    end
                    if (load_start) begin m_run = 1'b0; m_ptr = 0; end
                end else begin
                    if (load_start) m_ptr = 0;
                    else begin
                        if (load_valid) begin
                            m_prog[m_ptr] = load_data;
                            m_known[m_ptr] = 1'b1;
                            m_ptr++;
                            if (m_ptr == PROG) begin m_run = 1'b1; m_ptr = 0; end
                        end
                        if (load_done) m_run = 1'b1;
                    end
                end
                if (ov_set) m_ov = 1'b1;
                else if (ov_clr) m_ov = 1'b0;
            end
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on each transfer
    initial begin
        logic [8:0] r;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check1("cpu_reset", cpu_reset, !m_run);
                check1("load_ready", load_ready, !m_run);
                check1("out_valid", out_valid, exp_q.size() != 0);
                r = model_read(cpu_address);
                if (r[8]) check8("cpu_rdata", cpu_rdata, r[7:0]);
                if (exp_q.size() != 0) begin
                    if (out_ready) begin
                        check8("out_data", out_data, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end else begin
                    check8("out_data_empty", out_data, 8'h00);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
        cpu_address = a;
        cpu_write = 1'b0;
        @(negedge clk);
        check8(name, cpu_rdata, exp);
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cpu_address = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_address = 8'h00; cpu_wdata = 8'h00; cpu_write = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_done = 1'b0;
        out_ready = 1'b0;
        step(); step();
        reset = 1'b0;

        rd_chk(8'h12, 8'h00, "tick_0");
        rd_chk(8'h12, 8'h01, "tick_1");
        rd_chk(8'h12, 8'h02, "tick_2");
        rd_chk(8'h11, 8'h01, "status_reset");

        cpu_address = 8'h80;
        for (int i = 0; i < PROG; i++) begin
            load_valid = 1'b1;
            load_data = 8'(i);
            step();
        end
        load_valid = 1'b0;
        @(negedge clk);
        check1("run_after_full_load", cpu_reset, 1'b0);
        check1("load_ready_run", load_ready, 1'b0);
        check8("prog_0x80", cpu_rdata, 8'h00);
        step();
        rd_chk(8'hFF, 8'h7F, "prog_0xFF");

        wr(8'h0F, 8'h5A);
        rd_chk(8'h0F, 8'h5A, "ram_0x0F");
        wr(8'h90, 8'h77);
        rd_chk(8'h90, 8'h10, "prog_write_ignored");
        rd_chk(8'h40, 8'h00, "unmapped_0x40");

        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) wr(8'h10, 8'(i));
        rd_chk(8'h11, 8'h02, "status_full");
        wr(8'h10, 8'h09);
        rd_chk(8'h11, 8'h06, "status_overflow");
        out_ready = 1'b1;
        cpu_address = 8'h00;
        repeat (8) step();
        rd_chk(8'h11, 8'h05, "status_drained");
        wr(8'h11, 8'h04);
        rd_chk(8'h11, 8'h01, "status_cleared");

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'h10, 8'(8'h20 + i));
        out_ready = 1'b1;
        wr(8'h10, 8'hEE);
        rd_chk(8'h11, 8'h02, "full_push_with_pop");
        cpu_address = 8'h00;
        repeat (10) step();

        load_start = 1'b1;
        step();
        load_start = 1'b0;
        cpu_address = 8'h0F;
        @(negedge clk);
        check1("reload_cpu_reset", cpu_reset, 1'b1);
        check8("ram_retained", cpu_rdata, 8'h5A);
        step();

        load_valid = 1'b1; load_data = 8'hA1; step();
        load_data = 8'hB2; step();
        load_data = 8'hC3; load_done = 1'b1; step();
        load_valid = 1'b0; load_done = 1'b0;
        cpu_address = 8'h82;
        @(negedge clk);
        check1("run_after_done", cpu_reset, 1'b0);
        check8("prog_0x82", cpu_rdata, 8'hC3);
        step();
        rd_chk(8'h83, 8'h03, "prog_0x83_kept");

        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom % 400) == 0;
            load_start = ($urandom % 150) == 0;
            load_valid = !load_start && (($urandom % 2) == 0);
            load_done  = !load_start && (($urandom % 40) == 0);
            load_data  = 8'($urandom);
            out_ready  = ($urandom % 5) < 3;
            cpu_write  = ($urandom % 5) < 2;
            cpu_wdata  = 8'($urandom);
            case ($urandom % 4)
                0:       cpu_address = 8'($urandom % 16);
                1:       cpu_address = 8'(8'h10 + $urandom % 4);
                2:       cpu_address = 8'(8'h80 | ($urandom % 128));
                default: cpu_address = 8'($urandom);
            endcase
            step();
        end
        reset = 1'b0; cpu_write = 1'b0; load_valid = 1'b0; load_start = 1'b0; load_done = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Bus responder for the 8-bit CPU: it is the memory side of the CPU's address / data_out / write / data_in bus. It provides:
- a 16-byte RAM;
- a 128-byte program store at 0x80-0xFF, filled through a byte-stream loader while the CPU is held in reset;
- memory-mapped output FIFO, status and tick registers.

It sits between the CPU core and the test top level, replacing ad-hoc testbench memory.

## Interface
Parameters:
- FIFO_DEPTH, 8, output FIFO entries (power of two, 2..16)
- PROG_BYTES, 128, program store size; base fixed at 0x80

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_address  in  8  CPU address bus
- cpu_wdata  in  8  CPU data_out
- cpu_write  in  1  CPU write strobe
- cpu_rdata  out  8  data_in to CPU, combinational from cpu_address
- cpu_reset  out  1  holds CPU in reset while loading
- load_start  in  1  pulse: restart loader (enter LOAD, pointer=0)
- load_valid  in  1  load byte present
- load_data  in  8  load byte
- load_done  in  1  pulse: finish loading early
- load_ready  out  1  loader accepts a byte
- out_data  out  8  FIFO head byte, 0x00 when empty
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head

## Operation
Address map; reads are combinational, writes happen at the posedge where cpu_write=1:
- 0x00-0x0F: RAM, read/write.
- 0x10: OUTDATA. A write pushes cpu_wdata into the FIFO. A read returns 0x00.
- 0x11: STATUS. Read returns {5'b0, overflow, full, empty}. A write with bit2=1 clears overflow; other bits are ignored.
- 0x12: TICK. 8-bit free-running counter, +1 every cycle, wraps 0xFF->0x00. Writes are ignored.
- 0x13-0x7F: read 0x00, writes ignored.
- 0x80-0xFF: program store, read-only from the CPU; CPU writes are ignored.

Loader FSM has two states, LOAD and RUN:
- **LOAD:** cpu_reset=1, load_ready=1.
  - Each cycle with load_valid=1 writes load_data to 0x80+ptr, then ptr+1.
  - When the byte is accepted with ptr=PROG_BYTES-1, the FSM goes to RUN.
  - When load_done=1, the FSM goes to RUN. If load_valid=1 in the same cycle, that byte is written first.
  - Bytes not loaded keep their previous contents.
  - CPU writes are ignored in LOAD.
  - load_start in LOAD resets ptr to 0 and the FSM stays in LOAD.
- **RUN:** cpu_reset=0, load_ready=0.
  - load_valid and load_done are ignored.
  - load_start moves the FSM to LOAD with ptr=0. A CPU write in that same cycle still completes.
  - RAM, FIFO and flags are retained across reloads.

Output FIFO:
- Pop occurs when out_valid && out_ready.
- A push is accepted when count<FIFO_DEPTH, or when a pop happens in the same cycle.
- Otherwise the pushed byte is dropped and overflow is set (sticky).
- A push into an empty FIFO is not visible until the next cycle; no same-cycle bypass.
- empty = (count==0); full = (count==FIFO_DEPTH).
- Overflow set and a STATUS clear in the same cycle: set wins.

Reset values:
- State LOAD, ptr=0, cpu_reset=1, load_ready=1.
- FIFO empty, out_valid=0, out_data=0x00, overflow=0, tick=0x00.
- RAM cleared to 0x00.
- Program store not cleared.

## Timing
- cpu_rdata is valid in the same cycle as cpu_address, matching the CPU's one-cycle select->decode fetch.
- Write-then-read: a read in the cycle after a write returns the new value.
- cpu_write is treated as a one-cycle strobe. A held strobe writes every cycle, so each held cycle pushes to the FIFO.
- LOAD->RUN is registered: cpu_reset falls in the cycle after the final accepted byte or load_done edge. The CPU then starts at 0x80.
- RUN->LOAD is registered: cpu_reset rises in the cycle after load_start.
- FIFO latency: out_valid rises in the cycle after a push into an empty FIFO.
- Throughput: one push and one pop per cycle.
- Reset mid-load or mid-run: all state returns to reset values on the next edge, except the program store.

## Test plan
- **Reset:** reset high 2 cycles -> cpu_reset=1, load_ready=1, out_valid=0, STATUS read=0x01, TICK=0x00 then 0x01, 0x02.
- **Full load:** stream 128 bytes (value i at step i) -> cpu_reset=0 one cycle after the last byte; reads of 0x80 and 0xFF return 0x00 and 0x7F; load_ready=0.
- **Early load:** load 3 bytes 0xA1, 0xB2, 0xC3, asserting load_done with the third -> 0x82 reads 0xC3; RUN next cycle; 0x83 keeps its old value.
- **RAM access:** write 0x5A to 0x0F -> next-cycle read of 0x0F = 0x5A. Write 0x77 to 0x90 -> 0x90 unchanged. Read 0x40 -> 0x00.
- **FIFO overflow:** out_ready=0, push 0x01..0x09 -> after the 8th push STATUS=0x02; after the 9th STATUS=0x06. Then out_ready=1 -> pops 0x01..0x08 and STATUS=0x05. Write 0x04 to 0x11 -> STATUS=0x01.
- **FIFO full corner and reload:** FIFO full, push with out_ready=1 in the same cycle -> push accepted, overflow stays 0. load_start in RUN -> cpu_reset=1 next cycle; RAM 0x0F still reads 0x5A.
